// File: rtl/msi_irq_scheduler.sv
// msi_irq_scheduler: shares one MSI request/grant handshake
// among N_SRC edge-triggered interrupt sources, round robin.
module msi_irq_scheduler #(
  parameter int N_SRC   = 4,
  parameter int TIMEOUT = 1024,
  parameter int GAP     = 4
) (
  input  logic             axi_clk_pcie,
  input  logic             sys_resetn,
  input  logic [N_SRC-1:0] irq_in,
  input  logic [N_SRC-1:0] irq_mask,
  input  logic             link_up,
  input  logic             msi_enabled,
  input  logic [2:0]       msi_vector_width,
  input  logic             msi_grant,
  output logic             msi_request,
  output logic [4:0]       msi_vector_num,
  output logic [N_SRC-1:0] irq_pending,
  output logic [N_SRC-1:0] irq_ack,
  output logic             timeout_err,
  output logic             busy
);

  localparam int SW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int CW = $clog2(TIMEOUT);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_GAP
  } state_t;

  state_t           r_state;
  logic [SW-1:0]    r_sel;
  logic [SW-1:0]    r_rr;
  logic [CW-1:0]    r_wcnt;
  logic [GW-1:0]    r_gcnt;
  logic             r_req;
  logic [4:0]       r_vec;
  logic [N_SRC-1:0] r_ack;
  logic             r_to;
  logic             r_busy;
  logic [N_SRC-1:0] r_pend;
  logic [N_SRC-1:0] r_prev;

  logic [N_SRC-1:0] w_edge;
  logic [N_SRC-1:0] w_elig;
  logic [N_SRC-1:0] w_sel_oh;
  logic [N_SRC-1:0] w_clr;
  logic             w_live;
  logic             w_go;
  logic             w_grant_ok;
  logic             w_found;
  logic [SW-1:0]    w_pick;
  logic [SW-1:0]    w_rr_nxt;
  logic [2:0]       w_vwc;
  logic [5:0]       w_vm6;
  logic [4:0]       w_vec;

  assign w_edge     = irq_in & ~r_prev;
  assign w_elig     = r_pend & ~irq_mask;
  assign w_live     = link_up & msi_enabled;
  assign w_go       = w_live & (|w_elig);
  assign w_grant_ok = (r_state == S_REQ) & msi_grant & w_live;
  assign w_clr      = w_grant_ok ? w_sel_oh : '0;

  // widths above 5 behave as 5 (32 vectors max)
  assign w_vwc = (msi_vector_width > 3'd5) ? 3'd5 : msi_vector_width;
  assign w_vm6 = (6'd1 << w_vwc) - 6'd1;
  assign w_vec = 5'(w_pick) & w_vm6[4:0];

  assign w_rr_nxt = (r_sel == SW'(N_SRC - 1)) ? '0 : r_sel + 1'b1;

  // first eligible source at or above rr, wrapping
  always_comb begin
    int idx;
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = 0; k < N_SRC; k++) begin
      idx = int'(r_rr) + k;
      if (idx >= N_SRC) idx = idx - N_SRC;
      if (!w_found && w_elig[idx]) begin
        w_found = 1'b1;
        w_pick  = SW'(idx);
      end
    end
  end

  // one-hot of the source being served
  always_comb begin
    w_sel_oh = '0;
    for (int i = 0; i < N_SRC; i++)
      w_sel_oh[i] = (r_sel == SW'(i));
  end

  // pending latch: new edge beats grant clear, link down wipes all
  always_ff @(posedge axi_clk_pcie or negedge sys_resetn) begin
    if (!sys_resetn) begin
      r_prev <= '0;
      r_pend <= '0;
    end else begin
      r_prev <= irq_in;
      if (!link_up) r_pend <= '0;
      else          r_pend <= (r_pend & ~w_clr) | w_edge;
    end
  end

  // request FSM with registered handshake outputs
  always_ff @(posedge axi_clk_pcie or negedge sys_resetn) begin
    if (!sys_resetn) begin
      r_state <= S_IDLE;
      r_sel   <= '0;
      r_rr    <= '0;
      r_wcnt  <= '0;
      r_gcnt  <= '0;
      r_req   <= 1'b0;
      r_vec   <= '0;
      r_ack   <= '0;
      r_to    <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_ack <= '0;
      r_to  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_go) begin
            r_state <= S_REQ;
            r_sel   <= w_pick;
            r_vec   <= w_vec;
            r_req   <= 1'b1;
            r_busy  <= 1'b1;
            r_wcnt  <= '0;
          end
        end
        S_REQ: begin
          if (!w_live) begin
            r_state <= S_GAP;
            r_req   <= 1'b0;
            r_gcnt  <= '0;
          end else if (msi_grant) begin
            r_state <= S_GAP;
            r_req   <= 1'b0;
            r_gcnt  <= '0;
            r_ack   <= w_sel_oh;
            r_rr    <= w_rr_nxt;
          end else if (r_wcnt == CW'(TIMEOUT - 1)) begin
            r_state <= S_GAP;
            r_req   <= 1'b0;
            r_gcnt  <= '0;
            r_to    <= 1'b1;
            r_rr    <= w_rr_nxt;
          end else begin
            r_wcnt <= r_wcnt + 1'b1;
          end
        end
        S_GAP: begin
          if (r_gcnt == GW'(GAP - 1)) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_gcnt <= r_gcnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign msi_request    = r_req;
  assign msi_vector_num = r_vec;
  assign irq_pending    = r_pend;
  assign irq_ack        = r_ack;
  assign timeout_err    = r_to;
  assign busy           = r_busy;

endmodule

// File: tb/tb_msi_irq_scheduler.sv
// tb_msi_irq_scheduler: scoreboard bench for msi_irq_scheduler
// (N_SRC=4, TIMEOUT=16, GAP=4).
module tb_msi_irq_scheduler;

  localparam int N   = 4;
  localparam int TO  = 16;
  localparam int GP  = 4;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] irq_in;
  logic [N-1:0] irq_mask;
  logic         link_up;
  logic         msi_en;
  logic [2:0]   vw;
  logic         grant;
  logic         req;
  logic [4:0]   vnum;
  logic [N-1:0] pend;
  logic [N-1:0] ack;
  logic         to_err;
  logic         busy;

  msi_irq_scheduler #(
    .N_SRC(N), .TIMEOUT(TO), .GAP(GP)
  ) dut (
    .axi_clk_pcie     (clk),
    .sys_resetn       (rst_n),
    .irq_in           (irq_in),
    .irq_mask         (irq_mask),
    .link_up          (link_up),
    .msi_enabled      (msi_en),
    .msi_vector_width (vw),
    .msi_grant        (grant),
    .msi_request      (req),
    .msi_vector_num   (vnum),
    .irq_pending      (pend),
    .irq_ack          (ack),
    .timeout_err      (to_err),
    .busy             (busy)
  );

  typedef struct packed {
    logic         to;
    logic [N-1:0] ack;
    logic [4:0]   vec;
  } exp_t;

  exp_t sb[$];
  int   n_chk;
  int   n_fail;
  int   hi_cnt;
  int   hi_len;
  int   lo_cnt;
  bit   seen_fall;
  logic [4:0] last_vec;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic t,
                      input logic [N-1:0] a,
                      input logic [4:0] v);
    exp_t e;
    e.to  = t;
    e.ack = a;
    e.vec = v;
    sb.push_back(e);
  endtask

  task automatic pulse(input logic [N-1:0] m);
    irq_in = m;
    tick(1);
    irq_in = '0;
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    while (!req && n < 60) begin
      tick(1);
      n++;
    end
    check("req_seen", req, 1);
  endtask

  task automatic serve(input int dly);
    wait_req();
    tick(dly - 1);
    grant = 1'b1;
    tick(1);
    grant = 1'b0;
    check("req_drop", req, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(1);
  endtask

  // scoreboard pop on ack / timeout, request shape tracking
  always @(negedge clk) begin
    if (!rst_n) begin
      hi_cnt    = 0;
      lo_cnt    = 0;
      seen_fall = 1'b0;
    end else begin
      if (ack != '0 || to_err) begin
        if (sb.size() == 0) begin
          check("sb_unexpected", {to_err, ack}, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("sb_to", to_err, e.to);
          check("sb_ack", ack, e.ack);
          check("sb_vec", last_vec, e.vec);
        end
      end
      if (req) begin
        if (hi_cnt == 0 && seen_fall)
          check("gap_len", lo_cnt >= GP, 1);
        last_vec = vnum;
        hi_cnt++;
        lo_cnt = 0;
      end else begin
        if (hi_cnt > 0) begin
          hi_len    = hi_cnt;
          seen_fall = 1'b1;
        end
        hi_cnt = 0;
        lo_cnt++;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    hi_len   = 0;
    last_vec = '0;
    rst_n    = 1'b0;
    irq_in   = '0;
    irq_mask = '0;
    link_up  = 1'b1;
    msi_en   = 1'b1;
    vw       = 3'd5;
    grant    = 1'b0;
    tick(2);
    check("rst_req", req, 0);
    check("rst_vec", vnum, 0);
    check("rst_pend", pend, 0);
    check("rst_ack", ack, 0);
    check("rst_to", to_err, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick(1);

    // single source 2, grant in 5th REQ cycle
    push(1'b0, 4'b0100, 5'd2);
    pulse(4'b0100);
    check("s_pend", pend, 4'b0100);
    check("s_req0", req, 0);
    tick(1);
    check("s_req1", req, 1);
    check("s_vec", vnum, 2);
    check("s_busy", busy, 1);
    tick(4);
    grant = 1'b1;
    tick(1);
    grant = 1'b0;
    check("s_req_lo", req, 0);
    check("s_ack", ack, 4'b0100);
    check("s_pend0", pend, 0);
    tick(1);
    check("s_hi_len", hi_len, 5);
    check("s_ack_1cyc", ack, 0);
    tick(2);
    check("s_gap_busy", busy, 1);
    tick(1);
    check("s_idle", busy, 0);

    // round robin from rr=0
    do_reset();
    push(1'b0, 4'b0001, 5'd0);
    push(1'b0, 4'b0010, 5'd1);
    irq_in = 4'b1011;
    tick(1);
    irq_in = '0;
    check("rr_pend", pend, 4'b1011);
    serve(2);
    serve(2);
    push(1'b0, 4'b1000, 5'd3);
    push(1'b0, 4'b0001, 5'd0);
    pulse(4'b0001);
    check("rr_pend2", pend, 4'b1001);
    serve(2);
    serve(2);
    tick(GP + 2);
    check("rr_empty", pend, 0);

    // timeout on source 1, then grant exactly on last cycle
    push(1'b1, 4'b0000, 5'd1);
    pulse(4'b0010);
    wait_req();
    tick(TO - 1);
    check("to_still_hi", req, 1);
    tick(1);
    check("to_req_lo", req, 0);
    check("to_err", to_err, 1);
    check("to_pend", pend, 4'b0010);
    tick(1);
    check("to_hi_len", hi_len, TO);
    push(1'b0, 4'b0010, 5'd1);
    serve(TO);
    check("to_none", to_err, 0);
    check("to_ack", ack, 4'b0010);
    tick(GP + 2);

    // vector width masking
    vw = 3'd1;
    push(1'b0, 4'b1000, 5'd1);
    pulse(4'b1000);
    serve(1);
    tick(GP + 2);
    vw = 3'd0;
    push(1'b0, 4'b1000, 5'd0);
    pulse(4'b1000);
    serve(1);
    tick(GP + 2);
    vw = 3'd7;
    push(1'b0, 4'b1000, 5'd3);
    pulse(4'b1000);
    serve(1);
    tick(GP + 2);
    vw = 3'd5;

    // gating by msi_enabled and link_up
    msi_en = 1'b0;
    pulse(4'b0001);
    tick(3);
    check("g_noreq", req, 0);
    check("g_idle", busy, 0);
    check("g_pend", pend, 4'b0001);
    msi_en = 1'b1;
    tick(1);
    check("g_req", req, 1);
    check("g_vec", vnum, 0);
    tick(2);
    link_up = 1'b0;
    tick(1);
    check("g_link_req", req, 0);
    check("g_link_pend", pend, 0);
    check("g_link_ack", ack, 0);
    link_up = 1'b1;
    tick(GP + 2);

    // masking
    irq_mask = 4'b0010;
    pulse(4'b0010);
    tick(3);
    check("m_pend", pend, 4'b0010);
    check("m_idle", busy, 0);
    check("m_noreq", req, 0);
    irq_mask = '0;
    push(1'b0, 4'b0010, 5'd1);
    serve(1);
    tick(GP + 2);
    push(1'b0, 4'b0100, 5'd2);
    pulse(4'b0100);
    wait_req();
    irq_mask = 4'b0100;
    serve(2);
    irq_mask = '0;
    tick(GP + 2);

    // new edge on served source in its grant cycle
    push(1'b0, 4'b0001, 5'd0);
    push(1'b0, 4'b0001, 5'd0);
    pulse(4'b0001);
    wait_req();
    tick(1);
    grant  = 1'b1;
    irq_in = 4'b0001;
    tick(1);
    grant  = 1'b0;
    irq_in = '0;
    check("sim_ack", ack, 4'b0001);
    check("sim_pend", pend, 4'b0001);
    serve(1);
    tick(GP + 2);
    check("sim_pend0", pend, 0);

    // async reset in the middle of REQ
    pulse(4'b0100);
    wait_req();
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_req", req, 0);
    check("ar_pend", pend, 0);
    check("ar_busy", busy, 0);
    tick(2);
    rst_n = 1'b1;
    tick(3);
    check("ar_stay", req, 0);

    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
